// File: rtl/cas_tape_player.sv
// cas_tape_player: cassette playback engine. Streams a .CAS image out of
// memory one byte at a time and turns it into the FSK square wave expected
// on the cassette input (a 1 bit is one cycle at F1_HZ, a 0 bit is one cycle
// at F0_HZ, LSB first, no gaps). A one-byte prefetch hides memory latency.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   motor               relay; 1 = tape runs, 0 = bit engine frozen mid-bit
//   rewind, load        level; either holds the transport at position 0
//   tape_len            image length in bytes
//   mem_addr/mem_rd     read address and one-cycle read strobe
//   mem_data/mem_ready  read data and its one-cycle valid strobe
//   cas_out             FSK bit stream
//   playing             motor on and tape neither idle nor at its end
//   eot                 every tape_len byte has been emitted
//   tape_pos            index of the byte currently being emitted
module cas_tape_player #(
  parameter int CLK_HZ = 57272000,
  parameter int F0_HZ  = 1200,
  parameter int F1_HZ  = 2400,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              motor,
  input  logic              rewind,
  input  logic              load,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              cas_out,
  output logic              playing,
  output logic              eot,
  output logic [ADDR_W-1:0] tape_pos
);

  localparam int HALF0 = CLK_HZ / (2 * F0_HZ);
  localparam int HALF1 = CLK_HZ / (2 * F1_HZ);
  localparam int CW    = $clog2(HALF0 + 1);
  localparam logic [CW-1:0] H0M1 = CW'(HALF0 - 1);
  localparam logic [CW-1:0] H1M1 = CW'(HALF1 - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_END} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0] pos;
  logic [7:0]        cur, nxt;
  logic              nxt_vld;   // prefetch buffer holds byte pos+1
  logic              pend;      // one read in flight
  logic              active;    // bit engine running (0 = underrun stall)
  logic              phase;     // 1 = high half of current bit
  logic [2:0]        bit_idx;
  logic [CW-1:0]     cnt;

  logic              clr, rdy_ok, tick, half_end, bit_end, byte_end, last;
  logic [CW-1:0]     half_m1;
  logic [ADDR_W:0]   pos_p1, pos_p2, len_x;
  logic [7:0]        nxt_byte;
  logic              start, fill, adv, stall, resume;

  assign clr      = reset | rewind | load;
  assign rdy_ok   = mem_ready & pend;
  assign pos_p1   = {1'b0, pos} + {{ADDR_W{1'b0}}, 1'b1};
  assign pos_p2   = {1'b0, pos} + {{(ADDR_W-1){1'b0}}, 2'd2};
  assign len_x    = {1'b0, tape_len};
  // >= rather than == so a tape_len shrunk under a running tape still ends it
  assign last     = (pos_p1 >= len_x);
  assign tick     = (state == S_PLAY) & active & motor;
  assign half_m1  = cur[bit_idx] ? H1M1 : H0M1;
  assign half_end = tick & (cnt == half_m1);
  assign bit_end  = half_end & ~phase;
  assign byte_end = bit_end & (bit_idx == 3'd7);
  // a response landing exactly on the byte boundary is used directly
  assign nxt_byte = nxt_vld ? nxt : mem_data;

  assign cas_out  = (state == S_PLAY) & active & phase;
  assign eot      = (state == S_END);
  assign playing  = motor & ((state == S_FILL) | (state == S_PLAY));
  assign tape_pos = pos;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    fill    = 1'b0;
    adv     = 1'b0;
    stall   = 1'b0;
    resume  = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          // a response still in flight from before the rewind is drained first
          if (!pend) begin
            if (tape_len == '0) state_d = S_END;
            else begin
              start   = 1'b1;
              state_d = S_FILL;
            end
          end
        end
        S_FILL: begin
          if (rdy_ok) begin
            fill    = 1'b1;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (byte_end) begin
            if (last)                   state_d = S_END;
            else if (nxt_vld || rdy_ok) adv     = 1'b1;
            else                        stall   = 1'b1;
          end else if (!active) begin
            if (last)        state_d = S_END;
            else if (rdy_ok) resume  = 1'b1;
          end
        end
        S_END: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos      <= '0;
      cur      <= '0;
      nxt      <= '0;
      nxt_vld  <= 1'b0;
      pend     <= 1'b0;
      active   <= 1'b0;
      phase    <= 1'b0;
      bit_idx  <= '0;
      cnt      <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd <= 1'b0;
      if (mem_ready) pend <= 1'b0;
      if (clr) begin
        pos     <= '0;
        nxt_vld <= 1'b0;
        active  <= 1'b0;
        phase   <= 1'b0;
        bit_idx <= '0;
        cnt     <= '0;
      end else begin
        if (start) begin
          mem_rd   <= 1'b1;
          mem_addr <= '0;
          pend     <= 1'b1;
        end
        if (fill) begin
          cur     <= mem_data;
          active  <= 1'b1;
          phase   <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          if (pos_p1 < len_x) begin
            mem_rd   <= 1'b1;
            mem_addr <= pos_p1[ADDR_W-1:0];
            pend     <= 1'b1;
          end
        end
        if (adv || resume) begin
          cur     <= adv ? nxt_byte : mem_data;
          pos     <= pos_p1[ADDR_W-1:0];
          nxt_vld <= 1'b0;
          active  <= 1'b1;
          phase   <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          if (pos_p2 < len_x) begin
            mem_rd   <= 1'b1;
            mem_addr <= pos_p2[ADDR_W-1:0];
            pend     <= 1'b1;
          end
        end else if (half_end) begin
          cnt <= '0;
          if (phase) phase <= 1'b0;
          else if (bit_idx != 3'd7) begin
            bit_idx <= bit_idx + 3'd1;
            phase   <= 1'b1;
          end else begin
            active  <= 1'b0;  // underrun stall or end of tape
          end
        end else if (tick) begin
          cnt <= cnt + 1'b1;
        end
        if (rdy_ok && (state == S_PLAY) && active && !byte_end) begin
          nxt     <= mem_data;
          nxt_vld <= 1'b1;
        end
      end
    end
  end

endmodule
